// File: rtl/biriscv_fetch_queue.sv
// In-order fetch-to-issue instruction queue: trims fetch packets by alignment offset and
// predicted-taken branch, compacts surviving slots into a circular buffer, issues up to ISSUE_WIDTH lanes.
module biriscv_fetch_queue #(
    parameter int FETCH_WIDTH   = 2,
    parameter int FETCH_WIDTH_W = 1,
    parameter int ISSUE_WIDTH   = 2,
    parameter int DEPTH         = 8,
    parameter int DEPTH_W       = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      fetch_valid_i,
    input  logic [32*FETCH_WIDTH-1:0] fetch_instr_i,
    input  logic [31:0]               fetch_pc_i,
    input  logic [FETCH_WIDTH-1:0]    fetch_pred_branch_i,
    input  logic                      fetch_fault_fetch_i,
    input  logic                      fetch_fault_page_i,
    output logic                      fetch_accept_o,
    output logic [ISSUE_WIDTH-1:0]    out_valid_o,
    output logic [32*ISSUE_WIDTH-1:0] out_instr_o,
    output logic [32*ISSUE_WIDTH-1:0] out_pc_o,
    output logic [ISSUE_WIDTH-1:0]    out_pred_taken_o,
    output logic [ISSUE_WIDTH-1:0]    out_fault_fetch_o,
    output logic [ISSUE_WIDTH-1:0]    out_fault_page_o,
    input  logic [ISSUE_WIDTH-1:0]    out_accept_i,
    output logic [DEPTH_W:0]          occupancy_o
);

    localparam int OFF_W = (FETCH_WIDTH_W > 0) ? FETCH_WIDTH_W : 1;
    localparam logic [DEPTH_W:0] ONE = (DEPTH_W+1)'(1);

    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        pc_q    [DEPTH];
    logic [DEPTH-1:0]   pred_q;
    logic [DEPTH-1:0]   ff_q;
    logic [DEPTH-1:0]   fp_q;

    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W:0]   count;

    logic [OFF_W-1:0]       off;
    logic [31:0]            pc_base;
    logic                   fault;
    logic                   taken_seen;
    logic [FETCH_WIDTH-1:0] slot_valid;
    logic [DEPTH_W-1:0]     slot_idx [FETCH_WIDTH];
    logic [DEPTH_W:0]       npush;
    logic [DEPTH_W:0]       push_cnt;
    logic                   push;
    logic [DEPTH_W:0]       npop;
    logic                   pop_run;
    logic [DEPTH_W:0]       free_slots;
    logic [DEPTH_W-1:0]     lane_idx [ISSUE_WIDTH];

    always_comb begin
        off = '0;
        if (FETCH_WIDTH > 1) off = fetch_pc_i[2 +: OFF_W];
    end

    assign pc_base = fetch_pc_i & ~32'(FETCH_WIDTH*4 - 1);
    assign fault   = fetch_fault_fetch_i | fetch_fault_page_i;

    // Slot survival plus a running prefix count gives each surviving slot its compacted write index.
    always_comb begin
        taken_seen = 1'b0;
        npush      = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            slot_valid[i] = fault ? (i == 32'(off)) : ((i >= 32'(off)) && !taken_seen);
            if (slot_valid[i] && fetch_pred_branch_i[i]) taken_seen = 1'b1;
            slot_idx[i] = wr_ptr + npush[DEPTH_W-1:0];
            if (slot_valid[i]) npush = npush + ONE;
        end
    end

    assign free_slots     = (DEPTH_W+1)'(DEPTH) - count;
    assign fetch_accept_o = (free_slots >= (DEPTH_W+1)'(FETCH_WIDTH)) && !flush_i;
    assign push           = fetch_valid_i && fetch_accept_o;
    assign push_cnt       = push ? npush : '0;

    always_comb begin
        out_valid_o       = '0;
        out_instr_o       = '0;
        out_pc_o          = '0;
        out_pred_taken_o  = '0;
        out_fault_fetch_o = '0;
        out_fault_page_o  = '0;
        for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
            lane_idx[k]          = rd_ptr + DEPTH_W'(k);
            out_valid_o[k]       = ((DEPTH_W+1)'(k) < count);
            out_instr_o[32*k +: 32] = instr_q[lane_idx[k]];
            out_pc_o[32*k +: 32]    = pc_q[lane_idx[k]];
            out_pred_taken_o[k]  = pred_q[lane_idx[k]];
            out_fault_fetch_o[k] = ff_q[lane_idx[k]];
            out_fault_page_o[k]  = fp_q[lane_idx[k]];
        end
    end

    // Only the unbroken run of accepted lanes from lane 0 is consumed.
    always_comb begin
        pop_run = 1'b1;
        npop    = '0;
        for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
            if (pop_run && out_valid_o[k] && out_accept_i[k]) npop = npop + ONE;
            else pop_run = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                if (slot_valid[i]) begin
                    instr_q[slot_idx[i]] <= fault ? '0 : fetch_instr_i[32*i +: 32];
                    pc_q[slot_idx[i]]    <= pc_base | 32'(4*i);
                    pred_q[slot_idx[i]]  <= fault ? 1'b0 : fetch_pred_branch_i[i];
                    ff_q[slot_idx[i]]    <= fetch_fault_fetch_i;
                    fp_q[slot_idx[i]]    <= fetch_fault_page_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + npop[DEPTH_W-1:0];
            wr_ptr <= wr_ptr + push_cnt[DEPTH_W-1:0];
            count  <= count + push_cnt - npop;
        end
    end

    assign occupancy_o = count;

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Randomised and directed bench for biriscv_fetch_queue against a queue-based packet model.
module tb_biriscv_fetch_queue;

    localparam int FW = 2;
    localparam int IW = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush;
    logic          fetch_valid;
    logic [63:0]   fetch_instr;
    logic [31:0]   fetch_pc;
    logic [1:0]    fetch_pred;
    logic          fetch_ff;
    logic          fetch_fp;
    logic          fetch_accept;
    logic [1:0]    out_valid;
    logic [63:0]   out_instr;
    logic [63:0]   out_pc;
    logic [1:0]    out_pred;
    logic [1:0]    out_ff;
    logic [1:0]    out_fp;
    logic [1:0]    out_accept;
    logic [3:0]    occupancy;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        ff;
        logic        fp;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    biriscv_fetch_queue #(
        .FETCH_WIDTH(FW), .FETCH_WIDTH_W(1), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .DEPTH_W(3)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush),
        .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr), .fetch_pc_i(fetch_pc),
        .fetch_pred_branch_i(fetch_pred), .fetch_fault_fetch_i(fetch_ff),
        .fetch_fault_page_i(fetch_fp), .fetch_accept_o(fetch_accept),
        .out_valid_o(out_valid), .out_instr_o(out_instr), .out_pc_o(out_pc),
        .out_pred_taken_o(out_pred), .out_fault_fetch_o(out_ff), .out_fault_page_o(out_fp),
        .out_accept_i(out_accept), .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    // Reference: apply one clock edge worth of queue behaviour from the current inputs.
    task automatic model_update();
        int n;
        int off;
        int base;
        bit acc;
        ent_t e;
        acc = ((DEPTH - q.size()) >= FW) && !flush;
        if (flush) begin
            q.delete();
            return;
        end
        n = 0;
        for (int k = 0; k < IW; k++) begin
            if (k < q.size() && out_accept[k]) n++;
            else break;
        end
        repeat (n) void'(q.pop_front());
        if (fetch_valid && acc) begin
            off  = (fetch_pc / 4) % FW;
            base = fetch_pc - (fetch_pc % (FW*4));
            if (fetch_ff || fetch_fp) begin
                e.instr = 0; e.pc = base + 4*off; e.pred = 0; e.ff = fetch_ff; e.fp = fetch_fp;
                q.push_back(e);
            end else begin
                for (int i = off; i < FW; i++) begin
                    e.instr = fetch_instr[32*i +: 32];
                    e.pc = base + 4*i; e.pred = fetch_pred[i]; e.ff = 0; e.fp = 0;
                    q.push_back(e);
                    if (fetch_pred[i]) break;
                end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; fetch_valid = 0; fetch_instr = '0; fetch_pc = '0;
        fetch_pred = '0; fetch_ff = 0; fetch_fp = 0; out_accept = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 0;
        #12;
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        vectors++; if (out_valid !== 2'b00) begin miscompares++; $display("FAIL reset_valid: got %b expected 00", out_valid); end
        @(posedge clk); #1; rst_i = 1; #1;
        vectors++; if (fetch_accept !== 1'b1) begin miscompares++; $display("FAIL reset_accept: got %b expected 1", fetch_accept); end
        q.delete();
        @(posedge clk); #1;
        vectors++; if (occupancy !== 4'd0 || out_valid !== 2'b00) begin
            miscompares++; $display("FAIL idle_after_reset: occ %0d valid %b expected 0 00", occupancy, out_valid); end
    endtask

    task automatic test_aligned();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        idle_inputs();
        fetch_valid = 1; fetch_pc = 32'h100; fetch_instr = {b, a};
        tick();
        fetch_valid = 0; #1;
        vectors++; if (out_valid !== 2'b11) begin miscompares++; $display("FAIL aligned_valid: got %b expected 11", out_valid); end
        vectors++; if (out_instr !== {b, a}) begin miscompares++; $display("FAIL aligned_instr: got %h expected %h", out_instr, {b, a}); end
        vectors++; if (out_pc !== {32'h104, 32'h100}) begin miscompares++; $display("FAIL aligned_pc: got %h expected 0000010400000100", out_pc); end
        out_accept = 2'b11;
        tick();
        out_accept = 2'b00; #1;
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL aligned_pop: got %0d expected 0", occupancy); end
    endtask

    task automatic test_offset_pred();
        logic [31:0] x, y;
        x = $urandom; y = $urandom;
        idle_inputs();
        fetch_valid = 1; fetch_pc = 32'h104; fetch_instr = {y, x};
        tick();
        fetch_valid = 0; #1;
        vectors++; if (occupancy !== 4'd1 || out_instr[31:0] !== y || out_pc[31:0] !== 32'h104) begin
            miscompares++; $display("FAIL offset_slot: occ %0d instr %h pc %h expected 1 %h 00000104", occupancy, out_instr[31:0], out_pc[31:0], y); end
        out_accept = 2'b01;
        tick();
        out_accept = 2'b00;
        fetch_valid = 1; fetch_pc = 32'h200; fetch_instr = {y, x}; fetch_pred = 2'b01;
        tick();
        fetch_valid = 0; fetch_pred = 0; #1;
        vectors++; if (occupancy !== 4'd1 || out_instr[31:0] !== x || out_pc[31:0] !== 32'h200) begin
            miscompares++; $display("FAIL pred_trunc: occ %0d instr %h pc %h expected 1 %h 00000200", occupancy, out_instr[31:0], out_pc[31:0], x); end
        vectors++; if (out_pred[0] !== 1'b1) begin miscompares++; $display("FAIL pred_flag: got %b expected 1", out_pred[0]); end
        out_accept = 2'b01;
        tick();
        out_accept = 2'b00;
    endtask

    task automatic test_fault();
        idle_inputs();
        fetch_valid = 1; fetch_pc = 32'h300; fetch_instr = {$urandom, $urandom}; fetch_fp = 1;
        tick();
        fetch_valid = 0; fetch_fp = 0; #1;
        vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL fault_occ: got %0d expected 1", occupancy); end
        vectors++; if (out_instr[31:0] !== 32'h0 || out_pc[31:0] !== 32'h300 || out_fp[0] !== 1'b1 || out_ff[0] !== 1'b0) begin
            miscompares++; $display("FAIL fault_entry: instr %h pc %h fp %b ff %b expected 0 300 1 0", out_instr[31:0], out_pc[31:0], out_fp[0], out_ff[0]); end
        out_accept = 2'b01;
        tick();
        out_accept = 2'b00;
    endtask

    task automatic test_full();
        idle_inputs();
        for (int p = 0; p < 4; p++) begin
            fetch_valid = 1; fetch_pc = 32'h400 + 32'(8*p); fetch_instr = {$urandom, $urandom};
            tick();
        end
        fetch_valid = 0; #1;
        vectors++; if (occupancy !== 4'd8) begin miscompares++; $display("FAIL full_occ: got %0d expected 8", occupancy); end
        vectors++; if (fetch_accept !== 1'b0) begin miscompares++; $display("FAIL full_accept: got %b expected 0", fetch_accept); end
        out_accept = 2'b11;
        tick();
        out_accept = 2'b00; #1;
        vectors++; if (occupancy !== 4'd6 || fetch_accept !== 1'b1) begin
            miscompares++; $display("FAIL after_pop: occ %0d accept %b expected 6 1", occupancy, fetch_accept); end
        fetch_valid = 1; fetch_pc = 32'h504; fetch_instr = {$urandom, $urandom};
        tick();
        fetch_valid = 0; #1;
        vectors++; if (occupancy !== 4'd7 || fetch_accept !== 1'b0) begin
            miscompares++; $display("FAIL seven_accept: occ %0d accept %b expected 7 0", occupancy, fetch_accept); end
    endtask

    task automatic test_random();
        bit   exp_acc;
        bit   exp_v;
        ent_t got;
        int   sz;
        for (int c = 0; c < 40; c++) begin
            flush       = 0;
            fetch_valid = 1'($urandom_range(0, 1));
            fetch_pc    = $urandom & 32'hffff_fffc;
            fetch_instr = {$urandom, $urandom};
            fetch_pred  = 2'($urandom);
            fetch_ff    = ($urandom_range(0, 9) == 0);
            fetch_fp    = ($urandom_range(0, 9) == 0);
            out_accept  = 2'($urandom);
            #1;
            exp_acc = ((DEPTH - q.size()) >= FW);
            vectors++; if (fetch_accept !== exp_acc) begin miscompares++; $display("FAIL rnd_accept c%0d: got %b expected %b", c, fetch_accept, exp_acc); end
            vectors++; if (occupancy !== 4'(q.size())) begin miscompares++; $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, occupancy, q.size()); end
            for (int k = 0; k < IW; k++) begin
                exp_v = (k < q.size());
                vectors++; if (out_valid[k] !== exp_v) begin miscompares++; $display("FAIL rnd_valid c%0d lane%0d: got %b expected %b", c, k, out_valid[k], exp_v); end
                if (exp_v) begin
                    got = {out_instr[32*k +: 32], out_pc[32*k +: 32], out_pred[k], out_ff[k], out_fp[k]};
                    vectors++; if (got !== q[k]) begin miscompares++; $display("FAIL rnd_entry c%0d lane%0d: got %h expected %h", c, k, got, q[k]); end
                end
            end
            tick();
        end
        idle_inputs();
        fetch_valid = 1; fetch_pc = 32'h700; fetch_instr = {$urandom, $urandom};
        tick();
        fetch_valid = 0; out_accept = 2'b10; sz = q.size();
        tick();
        out_accept = 2'b00; #1;
        vectors++; if (occupancy !== 4'(sz)) begin miscompares++; $display("FAIL nonprefix: got %0d expected %0d", occupancy, sz); end
    endtask

    task automatic test_flush();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
        fetch_valid = 1;
        fetch_pc = 32'h600; fetch_instr = {$urandom, $urandom}; tick();
        fetch_pc = 32'h608; fetch_instr = {$urandom, $urandom}; tick();
        fetch_pc = 32'h614; fetch_instr = {$urandom, $urandom}; tick();
        fetch_valid = 0; #1;
        vectors++; if (occupancy !== 4'd5) begin miscompares++; $display("FAIL flush_fill: got %0d expected 5", occupancy); end
        flush = 1; fetch_valid = 1; fetch_pc = 32'h620; out_accept = 2'b11; #1;
        vectors++; if (fetch_accept !== 1'b0) begin miscompares++; $display("FAIL flush_accept: got %b expected 0", fetch_accept); end
        tick();
        idle_inputs(); #1;
        vectors++; if (occupancy !== 4'd0 || out_valid !== 2'b00) begin
            miscompares++; $display("FAIL flush_empty: occ %0d valid %b expected 0 00", occupancy, out_valid); end
        tick();
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL flush_pkt_lost: got %0d expected 0", occupancy); end
    endtask

    task automatic test_midreset();
        idle_inputs();
        fetch_valid = 1; fetch_pc = 32'h800; fetch_instr = {$urandom, $urandom};
        tick();
        #2; rst_i = 0; #1;
        vectors++; if (occupancy !== 4'd0 || out_valid !== 2'b00) begin
            miscompares++; $display("FAIL midreset: occ %0d valid %b expected 0 00", occupancy, out_valid); end
        q.delete();
        @(posedge clk); #1;
        idle_inputs(); rst_i = 1;
        tick();
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL midreset_hold: got %0d expected 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset_pred();
        test_fault();
        test_full();
        test_random();
        test_flush();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
